// File: rtl/renkon_linebuf_ctrl.sv
// Line-buffer sequencer: streams raster-order image addresses and emits a
// window-valid strobe aligned to the line-buffer pipeline latency.
module renkon_linebuf_ctrl #(
    parameter int LWIDTH = 10,
    parameter int ADDR_W = 12,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              req,
    input  logic [LWIDTH-1:0] img_size,
    input  logic [LWIDTH-1:0] fil_size,
    input  logic [ADDR_W-1:0] in_base,
    output logic              ack,
    output logic              busy,
    output logic              buf_en,
    output logic [ADDR_W-1:0] img_addr,
    output logic              win_valid,
    output logic              win_last
);

    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LWIDTH-1:0] img_q, img_d;
    logic [LWIDTH-1:0] fil_q, fil_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LWIDTH-1:0] row_q, row_d;
    logic [LWIDTH-1:0] col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [LAT-1:0]    tap_pipe_q, tap_pipe_d;
    logic [LAT-1:0]    last_pipe_q, last_pipe_d;

    logic [LWIDTH-1:0] img_last;
    logic [LWIDTH-1:0] fil_m1;
    logic              pix_last;
    logic              tap_d;
    logic              last_tap_d;

    assign img_last = img_q - LWIDTH'(1);
    assign fil_m1   = fil_q - LWIDTH'(1);
    assign pix_last = (row_q == img_last) && (col_q == img_last);

    // fil_m1 wraps when fil_q is zero; the fil_q != 0 term masks that case.
    assign tap_d = (state_q == S_FEED) && (fil_q != '0) && (fil_q <= img_q) &&
                   (row_q >= fil_m1) && (col_q >= fil_m1);
    assign last_tap_d = tap_d && pix_last;

    assign tap_pipe_d[0]  = tap_d;
    assign last_pipe_d[0] = last_tap_d;
    for (genvar gi = 1; gi < LAT; gi++) begin : g_pipe
        assign tap_pipe_d[gi]  = tap_pipe_q[gi-1];
        assign last_pipe_d[gi] = last_pipe_q[gi-1];
    end

    always_comb begin
        state_d = state_q;
        img_d   = img_q;
        fil_d   = fil_q;
        base_d  = base_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    img_d   = img_size;
                    fil_d   = fil_size;
                    base_d  = in_base;
                    state_d = (img_size == '0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                row_d   = '0;
                col_d   = '0;
                addr_d  = base_q;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (pix_last) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (col_q == img_last) begin
                        col_d = '0;
                        row_d = row_q + LWIDTH'(1);
                    end else begin
                        col_d = col_q + LWIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q     <= S_IDLE;
            img_q       <= '0;
            fil_q       <= '0;
            base_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            addr_q      <= '0;
            drain_q     <= '0;
            tap_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            state_q     <= state_d;
            img_q       <= img_d;
            fil_q       <= fil_d;
            base_q      <= base_d;
            row_q       <= row_d;
            col_q       <= col_d;
            addr_q      <= addr_d;
            drain_q     <= drain_d;
            tap_pipe_q  <= tap_pipe_d;
            last_pipe_q <= last_pipe_d;
        end
    end

    assign ack       = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign buf_en    = (state_q == S_START);
    assign img_addr  = addr_q;
    assign win_valid = tap_pipe_q[LAT-1];
    assign win_last  = last_pipe_q[LAT-1];

endmodule

// File: tb/tb_renkon_linebuf_ctrl.sv
// Self-checking bench for renkon_linebuf_ctrl: per-frame scenarios compared
// against a raster/window model built from image and filter geometry.
module tb_renkon_linebuf_ctrl;

    localparam int LWIDTH = 10;
    localparam int ADDR_W = 12;
    localparam int LAT    = 4;
    localparam int DEPTH  = 1024;

    logic              clk;
    logic              xrst;
    logic              req;
    logic [LWIDTH-1:0] img_size;
    logic [LWIDTH-1:0] fil_size;
    logic [ADDR_W-1:0] in_base;
    logic              ack;
    logic              busy;
    logic              buf_en;
    logic [ADDR_W-1:0] img_addr;
    logic              win_valid;
    logic              win_last;

    int n_checks;
    int n_fail;

    bit exp_v [DEPTH];
    bit exp_l [DEPTH];

    renkon_linebuf_ctrl #(
        .LWIDTH(LWIDTH),
        .ADDR_W(ADDR_W),
        .LAT   (LAT)
    ) dut (
        .clk      (clk),
        .xrst     (xrst),
        .req      (req),
        .img_size (img_size),
        .fil_size (fil_size),
        .in_base  (in_base),
        .ack      (ack),
        .busy     (busy),
        .buf_en   (buf_en),
        .img_addr (img_addr),
        .win_valid(win_valid),
        .win_last (win_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame: accept at the posedge after the first negedge (cycle 0).
    // Cycle 1 is buf_en, cycles 2..n+1 carry addresses, ack follows drain.
    task automatic run_frame(input int img, input int fil, input int base,
                             input int hold, input int chg_at, input string name);
        int n, cyc, exp_win, exp_ack;
        int nbuf, buf_cyc, addr_err, nvalid, pos_err, nlast, ack_cyc;
        int busy_err, hold_err, first_v, tap_cyc;
        logic [ADDR_W-1:0] exp_addr, tap_addr;
        n        = img * img;
        exp_win  = (fil >= 1 && fil <= img) ? (img - fil + 1) * (img - fil + 1) : 0;
        exp_ack  = (n > 0) ? 2 + n + LAT : 1;
        tap_addr = ADDR_W'(base + (fil - 1) * img + (fil - 1));
        for (int i = 0; i < DEPTH; i++) begin
            exp_v[i] = 1'b0;
            exp_l[i] = 1'b0;
        end
        for (int r = 0; r < img; r++) begin
            for (int c = 0; c < img; c++) begin
                if (fil >= 1 && fil <= img && r >= fil - 1 && c >= fil - 1) begin
                    exp_v[2 + r * img + c + LAT] = 1'b1;
                    if (r == img - 1 && c == img - 1) exp_l[2 + r * img + c + LAT] = 1'b1;
                end
            end
        end
        nbuf = 0; buf_cyc = -1; addr_err = 0; nvalid = 0; pos_err = 0; nlast = 0;
        ack_cyc = -1; busy_err = 0; hold_err = 0; first_v = -1; tap_cyc = -1;

        @(negedge clk);
        img_size = LWIDTH'(img);
        fil_size = LWIDTH'(fil);
        in_base  = ADDR_W'(base);
        req      = 1'b1;
        cyc      = 0;
        while (ack_cyc < 0 && cyc < n + LAT + 20) begin
            @(negedge clk);
            cyc++;
            if (buf_en) begin
                nbuf++;
                buf_cyc = cyc;
            end
            if (cyc >= 2 && cyc < 2 + n) begin
                exp_addr = ADDR_W'(base + cyc - 2);
                if (img_addr !== exp_addr) addr_err++;
                if (img_addr === tap_addr && tap_cyc < 0) tap_cyc = cyc;
            end
            if (win_valid === 1'b1) begin
                nvalid++;
                if (first_v < 0) first_v = cyc;
            end
            if (win_valid !== exp_v[cyc]) pos_err++;
            if (win_last === 1'b1) nlast++;
            if (win_last !== exp_l[cyc]) pos_err++;
            if (busy !== 1'b1) busy_err++;
            if (ack === 1'b1) ack_cyc = cyc;
            if (cyc == chg_at) begin
                img_size = LWIDTH'($urandom_range(1, 30));
                fil_size = LWIDTH'($urandom_range(0, 6));
                in_base  = ADDR_W'($urandom);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (ack !== 1'b1 || buf_en !== 1'b0 || busy !== 1'b1) hold_err++;
        end
        req = 1'b0;
        @(negedge clk);

        n_checks++;
        if (nbuf !== ((n > 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s buf_en_count: got %0d want %0d", name, nbuf, (n > 0) ? 1 : 0);
        end
        if (n > 0) begin
            n_checks++;
            if (buf_cyc !== 1) begin
                n_fail++;
                $display("FAIL %s buf_en_cycle: got %0d want 1", name, buf_cyc);
            end
        end
        n_checks++;
        if (addr_err !== 0) begin
            n_fail++;
            $display("FAIL %s address_seq: %0d wrong addresses, want 0", name, addr_err);
        end
        n_checks++;
        if (nvalid !== exp_win) begin
            n_fail++;
            $display("FAIL %s win_count: got %0d want %0d", name, nvalid, exp_win);
        end
        n_checks++;
        if (pos_err !== 0) begin
            n_fail++;
            $display("FAIL %s win_timing: %0d misplaced strobes, want 0", name, pos_err);
        end
        n_checks++;
        if (nlast !== ((exp_win > 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s win_last_count: got %0d want %0d", name, nlast, (exp_win > 0) ? 1 : 0);
        end
        if (exp_win > 0) begin
            n_checks++;
            if (first_v - tap_cyc !== LAT) begin
                n_fail++;
                $display("FAIL %s first_win_latency: got %0d want %0d", name, first_v - tap_cyc, LAT);
            end
        end
        n_checks++;
        if (ack_cyc !== exp_ack) begin
            n_fail++;
            $display("FAIL %s ack_cycle: got %0d want %0d", name, ack_cyc, exp_ack);
        end
        n_checks++;
        if (busy_err !== 0 || hold_err !== 0) begin
            n_fail++;
            $display("FAIL %s busy_hold: busy_err %0d hold_err %0d want 0/0", name, busy_err, hold_err);
        end
        n_checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after_req_drop: ack %b busy %b want 0/0", name, ack, busy);
        end
        $display("frame %s img=%0d fil=%0d base=0x%03h: windows %0d (model %0d), ack at %0d (model %0d)",
                 name, img, fil, base, nvalid, exp_win, ack_cyc, exp_ack);
    endtask

    task automatic test_reset();
        xrst = 1'b0; req = 1'b0; img_size = '0; fil_size = '0; in_base = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ack, busy, buf_en, win_valid, win_last} !== 5'b0 || img_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ack %b busy %b buf_en %b wv %b wl %b addr %h want all 0",
                     ack, busy, buf_en, win_valid, win_last, img_addr);
        end
        xrst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || win_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy %b wv %b want 0/0", busy, win_valid);
        end
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_directed();
        run_frame(8, 5, 'h100, 0, 0, "img8_fil5");
        run_frame(5, 5, 'h020, 0, 0, "img5_fil5");
        run_frame(3, 1, 'h300, 0, 0, "img3_fil1");
        run_frame(1, 1, 'h7ff, 0, 0, "img1_fil1");
    endtask

    task automatic test_no_windows();
        run_frame(4, 6, 'h050, 0, 0, "fil_gt_img");
        run_frame(4, 0, 'h060, 0, 0, "fil_zero");
        run_frame(0, 3, 'h070, 0, 0, "img_zero");
    endtask

    task automatic test_addr_wrap();
        run_frame(8, 3, 'hFF0, 0, 0, "addr_wrap");
    endtask

    task automatic test_hold_and_change();
        run_frame(6, 3, 'h200, 10, 0, "hold_req");
        run_frame(7, 2, 'h400, 0, 10, "mid_change");
    endtask

    task automatic test_mid_reset();
        int wcnt;
        @(negedge clk);
        img_size = 10'd8; fil_size = 10'd3; in_base = 12'h040; req = 1'b1;
        repeat (2 + 3 * 8 + 2) @(negedge clk);
        xrst = 1'b0;
        #1;
        n_checks++;
        if ({ack, busy, buf_en, win_valid, win_last} !== 5'b0 || img_addr !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: ack %b busy %b buf_en %b wv %b wl %b addr %h want all 0",
                     ack, busy, buf_en, win_valid, win_last, img_addr);
        end
        @(negedge clk);
        xrst = 1'b1; req = 1'b0;
        wcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (win_valid !== 1'b0 || win_last !== 1'b0 || busy !== 1'b0) wcnt++;
        end
        n_checks++;
        if (wcnt !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_residue: %0d cycles with strobes/busy, want 0", wcnt);
        end
        $display("mid-frame reset: residue cycles %0d", wcnt);
        run_frame(8, 3, 'h040, 0, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_frame($urandom_range(1, 20), $urandom_range(0, 6), $urandom_range(0, 4095),
                      $urandom_range(0, 3), $urandom_range(0, 30), $sformatf("rand%0d", k));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_no_windows();
        test_addr_wrap();
        test_hold_and_change();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
